// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: access size codes and FSM state encoding.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit.
//
// Handshake: the master raises dmem_req_out and holds it, together with
// dmem_we_out, dmem_addr_out, dmem_wdata_out and dmem_wr_mask_out, stable
// until it samples dmem_ack_in high on a rising edge; that edge completes the
// access and dmem_rdata_in is captured on the same edge for reads. dmem_ack_in
// has no meaning while dmem_req_out is low. The master may also withdraw the
// request without an ack when it gives up waiting (timeout) or on reset.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req_out;
  logic              dmem_we_out;
  logic [ADDR_W-1:0] dmem_addr_out;
  logic [31:0]       dmem_wdata_out;
  logic [3:0]        dmem_wr_mask_out;
  logic [31:0]       dmem_rdata_in;
  logic              dmem_ack_in;

  modport master (
    output dmem_req_out,
    output dmem_we_out,
    output dmem_addr_out,
    output dmem_wdata_out,
    output dmem_wr_mask_out,
    input  dmem_rdata_in,
    input  dmem_ack_in
  );

  modport slave (
    input  dmem_req_out,
    input  dmem_we_out,
    input  dmem_addr_out,
    input  dmem_wdata_out,
    input  dmem_wr_mask_out,
    output dmem_rdata_in,
    output dmem_ack_in
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane logic of the load/store unit: store replication and write mask,
// command shape check, and load shift/extend. Purely combinational.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  cmd_size,
  input  logic [1:0]  cmd_offset,
  input  logic [31:0] cmd_store_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_mask,
  output logic        cmd_misaligned,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_offset,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Store side: replicate the data across lanes and enable only the addressed bytes.
  always_comb begin
    st_wdata = cmd_store_data;
    st_mask  = 4'b1111;
    case (cmd_size)
      SZ_BYTE: begin
        st_wdata = {4{cmd_store_data[7:0]}};
        st_mask  = 4'b0001 << cmd_offset;
      end
      SZ_HALF: begin
        st_wdata = {2{cmd_store_data[15:0]}};
        st_mask  = 4'b0011 << cmd_offset;
      end
      default: begin
        st_wdata = cmd_store_data;
        st_mask  = 4'b1111;
      end
    endcase
  end

  // Shape check: the reserved size code counts as misaligned so the FSM has one reject path.
  always_comb begin
    cmd_misaligned = 1'b0;
    case (cmd_size)
      SZ_BYTE: cmd_misaligned = 1'b0;
      SZ_HALF: cmd_misaligned = cmd_offset[0];
      SZ_WORD: cmd_misaligned = (cmd_offset != 2'b00);
      default: cmd_misaligned = 1'b1;
    endcase
  end

  // Load side: bring the addressed bytes down to bit 0, then sign- or zero-extend.
  always_comb begin
    shifted = rdata >> {ld_offset, 3'b000};
    ld_data = shifted;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one memory command from the decoder, runs a
// req/ack access on the data-memory port with a timeout, and returns aligned,
// extended load data. Malformed commands complete with an error and no access.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ld_req_in,
  input  logic              st_req_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_unsigned_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       store_data_in,
  output logic              lsu_busy_out,
  output logic              lsu_done_out,
  output logic [31:0]       load_data_out,
  output logic              err_out,
  output lsu_state_t        state_out,
  load_store_unit_if.master mem
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state;
  lsu_state_t        state_nxt;

  logic [CNT_W-1:0]  wait_cnt;
  logic              err_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [1:0]        offset_q;
  logic              unsigned_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        mask_q;
  logic [31:0]       load_data_q;

  logic [31:0]       st_wdata;
  logic [3:0]        st_mask;
  logic              cmd_misaligned;
  logic [31:0]       ld_data;

  logic              cmd_valid;
  logic              cmd_illegal;
  logic              timeout_hit;

  assign cmd_valid   = ld_req_in | st_req_in;
  assign cmd_illegal = (ld_req_in & st_req_in) | cmd_misaligned;
  assign timeout_hit = (wait_cnt == CNT_LAST);

  lsu_align u_align (
    .cmd_size       (load_size_in),
    .cmd_offset     (addr_in[1:0]),
    .cmd_store_data (store_data_in),
    .st_wdata       (st_wdata),
    .st_mask        (st_mask),
    .cmd_misaligned (cmd_misaligned),
    .ld_size        (size_q),
    .ld_offset      (offset_q),
    .ld_unsigned    (unsigned_q),
    .rdata          (mem.dmem_rdata_in),
    .ld_data        (ld_data)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: commands are only looked at in IDLE; ack wins over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = cmd_illegal ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (mem.dmem_ack_in || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status and request outputs decoded from the current state.
  always_comb begin
    lsu_busy_out     = 1'b0;
    lsu_done_out     = 1'b0;
    err_out          = 1'b0;
    mem.dmem_req_out = 1'b0;
    case (state)
      ACCESS: begin
        lsu_busy_out     = 1'b1;
        mem.dmem_req_out = 1'b1;
      end
      RESP: begin
        lsu_done_out = 1'b1;
        err_out      = err_q;
      end
      default: begin
        lsu_busy_out = 1'b0;
      end
    endcase
  end

  // Command latch, wait counter and load result capture.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wait_cnt    <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      offset_q    <= 2'b00;
      unsigned_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      load_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_illegal) begin
              err_q <= 1'b1;
            end else begin
              err_q      <= 1'b0;
              wait_cnt   <= '0;
              we_q       <= st_req_in;
              size_q     <= load_size_in;
              offset_q   <= addr_in[1:0];
              unsigned_q <= load_unsigned_in;
              addr_q     <= {addr_in[ADDR_W-1:2], 2'b00};
              wdata_q    <= st_wdata;
              mask_q     <= st_req_in ? st_mask : 4'b0000;
            end
          end
        end
        ACCESS: begin
          if (mem.dmem_ack_in) begin
            if (!we_q) begin
              load_data_q <= ld_data;
            end
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          err_q <= err_q;
        end
      endcase
    end
  end

  assign mem.dmem_we_out      = we_q;
  assign mem.dmem_addr_out    = addr_q;
  assign mem.dmem_wdata_out   = wdata_q;
  assign mem.dmem_wr_mask_out = mask_q;
  assign load_data_out        = load_data_q;
  assign state_out            = state;

endmodule
